// File: rtl/csi2_seq_pkg.sv
// Shared state encoding and default sizing for the CSI-2 frame sequencer.
package csi2_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LINE_REQ,
    LINE_XFER,
    LINE_GAP,
    FRAME_GAP
  } seq_state_t;

  localparam int SEQ_CNT_W            = 16;
  localparam int SEQ_GAP_W            = 8;
  localparam int SEQ_UNDERRUN_TIMEOUT = 64;
  // Shortest gap a timer can express: a zero load still spends one cycle.
  localparam int SEQ_MIN_GAP          = 1;

endpackage

// File: rtl/seq_gap_timer.sv
// Loadable down-counter; last_o flags the final cycle of a loaded interval.
// A load of 0 or 1 both give a single-cycle interval.
module seq_gap_timer
  import csi2_seq_pkg::*;
#(
  parameter int W = SEQ_CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q <= W'(SEQ_MIN_GAP));

endmodule

// File: rtl/csi2_frame_sequencer.sv
// Frame sequencer: requests lines, gates beats to CSI-2 TX with tuser/tlast, adds blanking.
// Data path is combinational (0 cycles); sink backpressure stalls the source and never counts as underrun.
module csi2_frame_sequencer
  import csi2_seq_pkg::*;
#(
  parameter int CNT_W            = SEQ_CNT_W,
  parameter int GAP_W            = SEQ_GAP_W,
  parameter int UNDERRUN_TIMEOUT = SEQ_UNDERRUN_TIMEOUT
) (
  input  logic             dphy_clk_200M,
  input  logic             rst_200mhz,
  input  logic             frame_start,
  input  logic             frame_abort,
  input  logic [CNT_W-1:0] cfg_lines,
  input  logic [CNT_W-1:0] cfg_words,
  input  logic [GAP_W-1:0] cfg_line_gap,
  input  logic [CNT_W-1:0] cfg_frame_gap,
  output logic             line_req,
  input  logic [23:0]      src_tdata,
  input  logic             src_tvalid,
  output logic             src_tready,
  output logic [31:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  output logic             busy,
  output logic [CNT_W-1:0] line_idx,
  output logic             frame_done,
  output logic             frame_err,
  output logic             err_underrun,
  output logic             err_cfg
);

  localparam int                IDLE_W    = $clog2(UNDERRUN_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(UNDERRUN_TIMEOUT);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] lines_q, words_q, frame_gap_q;
  logic [GAP_W-1:0] line_gap_q;
  logic [CNT_W-1:0] beat_q, beat_d, line_idx_q, line_idx_d;
  logic             err_underrun_q, err_underrun_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q, frame_err_d;
  logic             err_cfg_q, err_cfg_d;

  logic             xfer, beat_acc, last_beat, last_line, cfg_bad, start_acc;
  logic             gap_load, gap_last, idle_load, idle_last;
  logic [CNT_W-1:0] gap_val;

  assign xfer      = (state_q == LINE_XFER);
  assign cfg_bad   = (cfg_lines == '0) || (cfg_words == '0);
  assign start_acc = (state_q == IDLE) && frame_start && !frame_abort && !cfg_bad;
  assign beat_acc  = m_axis_tvalid && m_axis_tready;
  // Compare against count-1 so a full-scale cfg_words never needs the counter to wrap.
  assign last_beat = (beat_q == words_q - CNT_W'(1));
  assign last_line = (line_idx_q == lines_q - CNT_W'(1));

  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    line_idx_d     = line_idx_q;
    err_underrun_d = err_underrun_q;
    frame_done_d   = 1'b0;
    frame_err_d    = 1'b0;
    err_cfg_d      = 1'b0;
    gap_load       = 1'b0;
    gap_val        = '0;
    idle_load      = 1'b0;

    if (frame_abort) begin
      state_d    = IDLE;
      beat_d     = '0;
      line_idx_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (frame_start) begin
            if (cfg_bad) begin
              err_cfg_d = 1'b1;
            end else begin
              state_d        = LINE_REQ;
              err_underrun_d = 1'b0;
              beat_d         = '0;
              line_idx_d     = '0;
            end
          end
        end
        LINE_REQ: begin
          state_d   = LINE_XFER;
          idle_load = 1'b1;
        end
        LINE_XFER: begin
          if (beat_acc) begin
            idle_load = 1'b1;
            if (last_beat) begin
              beat_d     = '0;
              line_idx_d = line_idx_q + CNT_W'(1);
              gap_load   = 1'b1;
              if (last_line) begin
                state_d = FRAME_GAP;
                gap_val = frame_gap_q;
              end else if (line_gap_q == '0) begin
                state_d = LINE_REQ;
              end else begin
                state_d = LINE_GAP;
                gap_val = CNT_W'(line_gap_q);
              end
            end else begin
              beat_d = beat_q + CNT_W'(1);
            end
          end else if (!src_tvalid && idle_last) begin
            state_d        = IDLE;
            err_underrun_d = 1'b1;
            frame_err_d    = 1'b1;
            beat_d         = '0;
            line_idx_d     = '0;
          end
        end
        LINE_GAP: begin
          if (gap_last) state_d = LINE_REQ;
        end
        FRAME_GAP: begin
          if (gap_last) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
            line_idx_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge dphy_clk_200M or posedge rst_200mhz) begin
    if (rst_200mhz) begin
      state_q        <= IDLE;
      lines_q        <= '0;
      words_q        <= '0;
      line_gap_q     <= '0;
      frame_gap_q    <= '0;
      beat_q         <= '0;
      line_idx_q     <= '0;
      err_underrun_q <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_err_q    <= 1'b0;
      err_cfg_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      beat_q         <= beat_d;
      line_idx_q     <= line_idx_d;
      err_underrun_q <= err_underrun_d;
      frame_done_q   <= frame_done_d;
      frame_err_q    <= frame_err_d;
      err_cfg_q      <= err_cfg_d;
      if (start_acc) begin
        lines_q     <= cfg_lines;
        words_q     <= cfg_words;
        line_gap_q  <= cfg_line_gap;
        frame_gap_q <= cfg_frame_gap;
      end
    end
  end

  // Line/frame blanking share one timer; the underrun watchdog has its own.
  seq_gap_timer #(.W(CNT_W)) u_gap_timer (
    .clk_i      (dphy_clk_200M),
    .rst_i      (rst_200mhz),
    .clr_i      (frame_abort),
    .load_i     (gap_load),
    .load_val_i (gap_val),
    .dec_i      ((state_q == LINE_GAP) || (state_q == FRAME_GAP)),
    .last_o     (gap_last)
  );

  seq_gap_timer #(.W(IDLE_W)) u_idle_timer (
    .clk_i      (dphy_clk_200M),
    .rst_i      (rst_200mhz),
    .clr_i      (frame_abort),
    .load_i     (idle_load),
    .load_val_i (IDLE_LOAD),
    .dec_i      (xfer && !src_tvalid),
    .last_o     (idle_last)
  );

  assign m_axis_tvalid = src_tvalid && xfer && !frame_abort;
  assign src_tready    = m_axis_tready && xfer && !frame_abort;
  assign m_axis_tdata  = xfer ? {8'h00, src_tdata} : 32'h0;
  assign m_axis_tuser  = m_axis_tvalid && (line_idx_q == '0) && (beat_q == '0);
  assign m_axis_tlast  = m_axis_tvalid && last_beat;
  assign line_req      = (state_q == LINE_REQ) && !frame_abort;
  assign busy          = (state_q != IDLE);
  assign line_idx      = line_idx_q;
  assign frame_done    = frame_done_q;
  assign frame_err     = frame_err_q;
  assign err_underrun  = err_underrun_q;
  assign err_cfg       = err_cfg_q;

endmodule
